// File: rtl/cordic_arb_pkg.sv
// Shared widths, payload structs and the issue FSM encoding for the cordic
// requester arbiter.
package cordic_arb_pkg;

   localparam int DATA_W = 12;
   localparam int PHI_W  = 11;

   typedef struct packed {
      logic signed [DATA_W-1:0] re;
      logic signed [DATA_W-1:0] im;
   } cplx_t;

   typedef struct packed {
      logic        [DATA_W-1:0] amp;
      logic signed [PHI_W-1:0]  phi;
   } polar_t;

   typedef enum logic {
      IDLE,
      ISSUE
   } arb_state_e;

endpackage

// File: rtl/cordic_tag_fifo.sv
// Tag FIFO remembering which requester issued each in-flight cordic sample,
// so results can be steered back in issue order.
module cordic_tag_fifo #(
   parameter  int WIDTH = 2,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic [AW:0]      count_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   assign do_push = push_i && (!full_o || pop_i);
   assign do_pop  = pop_i && !empty_o;

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/cordic_arbiter.sv
// Round-robin front end sharing one cordic core among NUM_REQ requesters,
// with a tag FIFO steering results back to their issuers.
module cordic_arbiter
   import cordic_arb_pkg::*;
#(
   parameter  int NUM_REQ         = 4,
   parameter  int MAX_OUTSTANDING = 8,
   localparam int TAG_W           = $clog2(NUM_REQ),
   localparam int CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_re_i,
   input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_im_i,
   input  logic [NUM_REQ-1:0]               req_valid_i,
   output logic [NUM_REQ-1:0]               req_ready_o,
   output logic [DATA_W-1:0]                rsp_amp_o,
   output logic [PHI_W-1:0]                 rsp_phi_o,
   output logic [NUM_REQ-1:0]               rsp_valid_o,
   input  logic [NUM_REQ-1:0]               rsp_ready_i,
   output logic [DATA_W-1:0]                cor_re_o,
   output logic [DATA_W-1:0]                cor_im_o,
   output logic                             cor_valid_o,
   input  logic                             cor_ready_i,
   input  logic [DATA_W-1:0]                cor_amp_i,
   input  logic [PHI_W-1:0]                 cor_phi_i,
   input  logic                             cor_valid_i,
   output logic                             cor_ready_o,
   output logic [CNT_W-1:0]                 outstanding_o,
   output logic                             error_o
);

   arb_state_e       state_q, state_d;
   cplx_t            issue_q, issue_d;
   polar_t           result;
   logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [TAG_W-1:0] win_q, win_d, win_idx;
   logic             error_q, error_d;
   logic             any_req, grant, issue_hs, pop;
   logic [TAG_W-1:0] head_tag;
   logic             fifo_full, fifo_empty;
   int unsigned      idx;

   // First valid requester at or after rr_ptr, wrapping around.
   always_comb begin
      any_req = 1'b0;
      win_idx = '0;
      idx     = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = (int'(rr_ptr_q) + i) % NUM_REQ;
         if (!any_req && req_valid_i[TAG_W'(idx)]) begin
            any_req = 1'b1;
            win_idx = TAG_W'(idx);
         end
      end
   end

   assign grant    = (state_q == IDLE) && any_req && !fifo_full;
   assign issue_hs = (state_q == ISSUE) && cor_ready_i;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (grant)       state_d = ISSUE;
         ISSUE:   if (cor_ready_i) state_d = IDLE;
         default:                  state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready_o = '0;
      cor_valid_o = 1'b0;
      case (state_q)
         IDLE:    if (grant) req_ready_o[win_idx] = 1'b1;
         ISSUE:   cor_valid_o = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      issue_d  = issue_q;
      win_d    = win_q;
      rr_ptr_d = rr_ptr_q;
      if (grant) begin
         issue_d.re = req_re_i[win_idx];
         issue_d.im = req_im_i[win_idx];
         win_d      = win_idx;
         rr_ptr_d   = (win_idx == TAG_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         issue_q  <= '0;
         win_q    <= '0;
         rr_ptr_q <= '0;
         error_q  <= 1'b0;
      end else begin
         issue_q  <= issue_d;
         win_q    <= win_d;
         rr_ptr_q <= rr_ptr_d;
         error_q  <= error_d;
      end
   end

   assign cor_re_o = issue_q.re;
   assign cor_im_o = issue_q.im;

   // With no tag outstanding a result is orphaned: drain it and flag the error.
   always_comb begin
      rsp_valid_o = '0;
      cor_ready_o = 1'b1;
      if (!fifo_empty) begin
         rsp_valid_o[head_tag] = cor_valid_i;
         cor_ready_o           = rsp_ready_i[head_tag];
      end
   end

   assign pop     = cor_valid_i && cor_ready_o && !fifo_empty;
   assign error_d = error_q | (cor_valid_i & fifo_empty);
   assign error_o = error_q;

   assign result    = '{amp: cor_amp_i, phi: cor_phi_i};
   assign rsp_amp_o = result.amp;
   assign rsp_phi_o = result.phi;

   cordic_tag_fifo #(
      .WIDTH (TAG_W),
      .DEPTH (MAX_OUTSTANDING)
   ) u_tag_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (issue_hs),
      .data_i  (win_q),
      .pop_i   (pop),
      .head_o  (head_tag),
      .count_o (outstanding_o),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

endmodule

// File: tb/tb_cordic_arbiter.sv
// Bench for cordic_arbiter: a behavioural cordic stand-in with fixed latency,
// and a scoreboard of expected (requester, amp, phi) per granted sample.
module tb_cordic_arbiter;
   import cordic_arb_pkg::*;

   localparam int NUM_REQ = 4;
   localparam int MAX_OUT = 8;
   localparam int LAT     = 3;

   typedef struct {
      int                id;
      logic [DATA_W-1:0] amp;
      logic [PHI_W-1:0]  phi;
   } exp_t;

   typedef struct {
      logic [DATA_W-1:0] amp;
      logic [PHI_W-1:0]  phi;
      int                rdy;
   } pend_t;

   logic                           clk_i = 1'b0;
   logic                           rst_ni;
   logic [NUM_REQ-1:0][DATA_W-1:0] req_re_i, req_im_i;
   logic [NUM_REQ-1:0]             req_valid_i, req_ready_o;
   logic [DATA_W-1:0]              rsp_amp_o;
   logic [PHI_W-1:0]               rsp_phi_o;
   logic [NUM_REQ-1:0]             rsp_valid_o, rsp_ready_i;
   logic [DATA_W-1:0]              cor_re_o, cor_im_o;
   logic                           cor_valid_o, cor_ready_i;
   logic [DATA_W-1:0]              cor_amp_i;
   logic [PHI_W-1:0]               cor_phi_i;
   logic                           cor_valid_i, cor_ready_o;
   logic [$clog2(MAX_OUT):0]       outstanding_o;
   logic                           error_o;

   int   errors = 0;
   int   checks = 0;
   int   cyc_cnt = 0;
   bit   cor_rdy_en = 1'b1;
   bit   ret_stall = 1'b0;
   int   orphan_cnt = 0;
   int   orphan_done = 0;
   exp_t sb[$];
   int   grant_log[$];
   int   grant_cycs[$];
   int   pop_cycs[$];

   cordic_arbiter #(.NUM_REQ(NUM_REQ), .MAX_OUTSTANDING(MAX_OUT)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .req_re_i      (req_re_i),
      .req_im_i      (req_im_i),
      .req_valid_i   (req_valid_i),
      .req_ready_o   (req_ready_o),
      .rsp_amp_o     (rsp_amp_o),
      .rsp_phi_o     (rsp_phi_o),
      .rsp_valid_o   (rsp_valid_o),
      .rsp_ready_i   (rsp_ready_i),
      .cor_re_o      (cor_re_o),
      .cor_im_o      (cor_im_o),
      .cor_valid_o   (cor_valid_o),
      .cor_ready_i   (cor_ready_i),
      .cor_amp_i     (cor_amp_i),
      .cor_phi_i     (cor_phi_i),
      .cor_valid_i   (cor_valid_i),
      .cor_ready_o   (cor_ready_o),
      .outstanding_o (outstanding_o),
      .error_o       (error_o)
   );

   always #5 clk_i = ~clk_i;

   // Stand-in cordic transfer function; only needs to be deterministic and asymmetric in re/im.
   function automatic polar_t ref_result(logic signed [DATA_W-1:0] re, logic signed [DATA_W-1:0] im);
      polar_t r;
      r.amp = DATA_W'(re + im);
      r.phi = PHI_W'(re - im);
      return r;
   endfunction

   // Behavioural cordic: outputs change 1 time unit after posedge, handshakes read just before it.
   initial begin
      pend_t  pipe[$];
      polar_t r;
      bit     showing_orphan;
      int     mcyc;
      cor_valid_i = 1'b0;
      cor_amp_i   = '0;
      cor_phi_i   = '0;
      cor_ready_i = 1'b0;
      showing_orphan = 1'b0;
      mcyc = 0;
      forever begin
         @(posedge clk_i);
         mcyc++;
         #1;
         cor_ready_i    = cor_rdy_en;
         showing_orphan = 1'b0;
         if (rst_ni && pipe.size() > 0 && pipe[0].rdy <= mcyc && !ret_stall) begin
            cor_valid_i = 1'b1;
            cor_amp_i   = pipe[0].amp;
            cor_phi_i   = pipe[0].phi;
         end else if (rst_ni && pipe.size() == 0 && orphan_done < orphan_cnt) begin
            cor_valid_i    = 1'b1;
            cor_amp_i      = 12'h5A5;
            cor_phi_i      = 11'h123;
            showing_orphan = 1'b1;
         end else begin
            cor_valid_i = 1'b0;
            cor_amp_i   = '0;
            cor_phi_i   = '0;
         end
         #8;
         if (!rst_ni) begin
            pipe.delete();
         end else begin
            if (cor_valid_i && cor_ready_o) begin
               if (showing_orphan) orphan_done++;
               else void'(pipe.pop_front());
            end
            if (cor_valid_o && cor_ready_i) begin
               r = ref_result(cor_re_o, cor_im_o);
               pipe.push_back('{r.amp, r.phi, mcyc + LAT});
            end
         end
      end
   end

   // Runs just before each posedge: log grants into the scoreboard, check returned results.
   task automatic monitor();
      exp_t   e;
      polar_t r;
      cyc_cnt++;
      if (!rst_ni) begin
         sb.delete();
         return;
      end
      checks++;
      if (!$onehot0(req_ready_o)) begin
         errors++;
         $display("FAIL req_ready_onehot: got %b, want one-hot or zero", req_ready_o);
      end
      checks++;
      if (!$onehot0(rsp_valid_o)) begin
         errors++;
         $display("FAIL rsp_valid_onehot: got %b, want one-hot or zero", rsp_valid_o);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_valid_i[i] && req_ready_o[i]) begin
            r = ref_result(req_re_i[i], req_im_i[i]);
            sb.push_back('{i, r.amp, r.phi});
            grant_log.push_back(i);
            grant_cycs.push_back(cyc_cnt);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (rsp_valid_o[i] && rsp_ready_i[i]) begin
            pop_cycs.push_back(cyc_cnt);
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL rsp_unexpected: result on requester %0d, none expected", i);
            end else begin
               e = sb.pop_front();
               if (e.id != i || e.amp !== rsp_amp_o || e.phi !== rsp_phi_o) begin
                  errors++;
                  $display("FAIL rsp_data: got req=%0d amp=%0h phi=%0h, want req=%0d amp=%0h phi=%0h",
                           i, rsp_amp_o, rsp_phi_o, e.id, e.amp, e.phi);
               end
            end
         end
      end
   endtask

   // Called 1 unit after negedge; returns at the next negedge.
   task automatic cyc_step();
      #3;
      monitor();
      @(negedge clk_i);
   endtask

   task automatic drain();
      int k = 0;
      #1;
      while ((sb.size() != 0 || outstanding_o != 0) && k < 100) begin
         cyc_step();
         #1;
         k++;
      end
      checks++;
      if (k >= 100) begin
         errors++;
         $display("FAIL drain_timeout: sb=%0d outstanding=%0d, want 0 and 0", sb.size(), outstanding_o);
      end
      cyc_step();
   endtask

   task automatic apply_reset();
      rst_ni      = 1'b0;
      req_valid_i = '0;
      #1;
      cyc_step();
      rst_ni = 1'b1;
   endtask

   task automatic test_reset();
      rst_ni      = 1'b0;
      req_valid_i = '0;
      #1;
      cyc_step();
      #1;
      checks++;
      if (req_ready_o !== '0 || rsp_valid_o !== '0 || cor_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_handshakes: got rdy=%b rv=%b cv=%b, want 0", req_ready_o, rsp_valid_o, cor_valid_o);
      end
      checks++;
      if (outstanding_o !== '0 || error_o !== 1'b0 || cor_re_o !== '0 || cor_im_o !== '0) begin
         errors++;
         $display("FAIL reset_state: got out=%0d err=%b re=%0h im=%0h, want 0", outstanding_o, error_o, cor_re_o, cor_im_o);
      end
      rst_ni = 1'b1;
      cyc_step();
   endtask

   task automatic test_single();
      req_re_i[0]    = 12'd1000;
      req_im_i[0]    = 12'd500;
      req_valid_i    = 4'b0001;
      #1;
      checks++;
      if (req_ready_o !== 4'b0001 || outstanding_o !== 0) begin
         errors++;
         $display("FAIL single_grant: got rdy=%b out=%0d, want 0001 and 0", req_ready_o, outstanding_o);
      end
      cyc_step();
      req_valid_i = '0;
      #1;
      checks++;
      if (cor_valid_o !== 1'b1 || cor_re_o !== 12'd1000 || cor_im_o !== 12'd500 || req_ready_o !== '0) begin
         errors++;
         $display("FAIL single_issue: got cv=%b re=%0d im=%0d rdy=%b, want 1 1000 500 0000",
                  cor_valid_o, cor_re_o, cor_im_o, req_ready_o);
      end
      cyc_step();
      #1;
      checks++;
      if (outstanding_o !== 1 || cor_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL single_push: got out=%0d cv=%b, want 1 and 0", outstanding_o, cor_valid_o);
      end
      for (int k = 0; k < 20 && rsp_valid_o == '0; k++) begin
         cyc_step();
         #1;
      end
      checks++;
      if (rsp_valid_o !== 4'b0001) begin
         errors++;
         $display("FAIL single_rsp_valid: got %b, want 0001", rsp_valid_o);
      end
      cyc_step();
      #1;
      checks++;
      if (outstanding_o !== 0) begin
         errors++;
         $display("FAIL single_pop: got out=%0d, want 0", outstanding_o);
      end
      cyc_step();
   endtask

   task automatic test_round_robin();
      int base;
      int k = 0;
      apply_reset();
      base = grant_log.size();
      for (int i = 0; i < NUM_REQ; i++) begin
         req_re_i[i] = 12'(100 * (i + 1));
         req_im_i[i] = 12'(-37 * (i + 3));
      end
      req_valid_i = '1;
      while (grant_log.size() - base < 5 && k < 40) begin
         #1;
         cyc_step();
         k++;
      end
      req_valid_i = '0;
      checks++;
      if (grant_log.size() - base != 5) begin
         errors++;
         $display("FAIL rr_grant_count: got %0d, want 5", grant_log.size() - base);
      end
      for (int j = 0; j < 5 && base + j < grant_log.size(); j++) begin
         checks++;
         if (grant_log[base + j] != j % NUM_REQ) begin
            errors++;
            $display("FAIL rr_order: grant %0d went to %0d, want %0d", j, grant_log[base + j], j % NUM_REQ);
         end
      end
      drain();
   endtask

   task automatic test_issue_stall();
      cor_rdy_en  = 1'b0;
      req_re_i[2] = 12'(-300);
      req_im_i[2] = 12'd700;
      req_valid_i = 4'b0100;
      #1;
      checks++;
      if (req_ready_o !== 4'b0100) begin
         errors++;
         $display("FAIL stall_grant: got %b, want 0100", req_ready_o);
      end
      cyc_step();
      req_valid_i = '1;
      for (int k = 0; k < 5; k++) begin
         #1;
         checks++;
         if (cor_valid_o !== 1'b1 || cor_re_o !== 12'(-300) || cor_im_o !== 12'd700 || req_ready_o !== '0) begin
            errors++;
            $display("FAIL stall_hold: cycle %0d got cv=%b re=%0h im=%0h rdy=%b, want 1 ed4 2bc 0000",
                     k, cor_valid_o, cor_re_o, cor_im_o, req_ready_o);
         end
         cyc_step();
      end
      cor_rdy_en  = 1'b1;
      req_valid_i = '0;
      drain();
   endtask

   task automatic test_full();
      int base, gi, pi;
      int k = 0;
      ret_stall = 1'b1;
      base = grant_log.size();
      for (int i = 0; i < NUM_REQ; i++) begin
         req_re_i[i] = 12'($urandom_range(0, 4095));
         req_im_i[i] = 12'($urandom_range(0, 4095));
      end
      req_valid_i = '1;
      for (int c = 0; c < 30; c++) begin
         #1;
         cyc_step();
      end
      #1;
      checks++;
      if (grant_log.size() - base != MAX_OUT || outstanding_o !== 4'(MAX_OUT) || req_ready_o !== '0) begin
         errors++;
         $display("FAIL full_stall: got grants=%0d out=%0d rdy=%b, want 8 8 0000",
                  grant_log.size() - base, outstanding_o, req_ready_o);
      end
      gi = grant_cycs.size();
      pi = pop_cycs.size();
      ret_stall = 1'b0;
      while (grant_log.size() - base < 12 && k < 60) begin
         cyc_step();
         #1;
         k++;
      end
      req_valid_i = '0;
      checks++;
      if (grant_log.size() - base != 12) begin
         errors++;
         $display("FAIL full_total: got %0d grants, want 12", grant_log.size() - base);
      end
      checks++;
      if (grant_cycs.size() <= gi || pop_cycs.size() <= pi) begin
         errors++;
         $display("FAIL full_resume: no grant or pop seen after release");
      end else if (grant_cycs[gi] != pop_cycs[pi] + 1) begin
         errors++;
         $display("FAIL full_resume: grant at cycle %0d, want %0d", grant_cycs[gi], pop_cycs[pi] + 1);
      end
      cyc_step();
      drain();
   endtask

   task automatic test_rsp_backpressure();
      int base;
      int k = 0;
      rsp_ready_i = 4'b1101;
      base = grant_log.size();
      req_re_i[1] = 12'd321;
      req_im_i[1] = 12'd11;
      req_valid_i = 4'b0010;
      while (grant_log.size() - base < 2 && k < 20) begin
         #1;
         cyc_step();
         req_im_i[1] = 12'(11 + 13 * k);
         k++;
      end
      req_valid_i = '0;
      #1;
      k = 0;
      while (!(rsp_valid_o[1] && outstanding_o == 2) && k < 20) begin
         cyc_step();
         #1;
         k++;
      end
      for (int c = 0; c < 4; c++) begin
         checks++;
         if (rsp_valid_o !== 4'b0010 || cor_ready_o !== 1'b0 || outstanding_o !== 2) begin
            errors++;
            $display("FAIL bp_hold: got rv=%b crdy=%b out=%0d, want 0010 0 2", rsp_valid_o, cor_ready_o, outstanding_o);
         end
         cyc_step();
         #1;
      end
      cyc_step();
      rsp_ready_i[1] = 1'b1;
      #1;
      checks++;
      if (cor_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL bp_release: got crdy=%b, want 1", cor_ready_o);
      end
      cyc_step();
      rsp_ready_i[1] = 1'b0;
      #1;
      checks++;
      if (outstanding_o !== 1 || rsp_valid_o !== 4'b0010 || cor_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL bp_single_pop: got out=%0d rv=%b crdy=%b, want 1 0010 0", outstanding_o, rsp_valid_o, cor_ready_o);
      end
      rsp_ready_i = '1;
      cyc_step();
      drain();
   endtask

   task automatic test_error();
      int k = 0;
      orphan_cnt++;
      #1;
      while (cor_valid_i !== 1'b1 && k < 10) begin
         cyc_step();
         #1;
         k++;
      end
      checks++;
      if (cor_valid_i !== 1'b1 || rsp_valid_o !== '0 || cor_ready_o !== 1'b1 || error_o !== 1'b0) begin
         errors++;
         $display("FAIL orphan_drain: got cvi=%b rv=%b crdy=%b err=%b, want 1 0000 1 0",
                  cor_valid_i, rsp_valid_o, cor_ready_o, error_o);
      end
      cyc_step();
      #1;
      checks++;
      if (error_o !== 1'b1) begin
         errors++;
         $display("FAIL orphan_error_set: got %b, want 1", error_o);
      end
      for (int c = 0; c < 3; c++) begin
         cyc_step();
         #1;
      end
      checks++;
      if (error_o !== 1'b1 || outstanding_o !== 0) begin
         errors++;
         $display("FAIL orphan_error_sticky: got err=%b out=%0d, want 1 0", error_o, outstanding_o);
      end
      cyc_step();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < NUM_REQ; i++) begin
         req_re_i[i] = 12'($urandom_range(0, 4095));
         req_im_i[i] = 12'($urandom_range(0, 4095));
      end
      req_valid_i = '1;
      for (int c = 0; c < 7; c++) begin
         #1;
         cyc_step();
      end
      rst_ni      = 1'b0;
      req_valid_i = '0;
      #1;
      cyc_step();
      #1;
      checks++;
      if (req_ready_o !== '0 || rsp_valid_o !== '0 || cor_valid_o !== 1'b0 || outstanding_o !== 0 ||
          error_o !== 1'b0 || cor_re_o !== '0 || cor_im_o !== '0) begin
         errors++;
         $display("FAIL midreset_state: got rdy=%b rv=%b cv=%b out=%0d err=%b re=%0h im=%0h, want all 0",
                  req_ready_o, rsp_valid_o, cor_valid_o, outstanding_o, error_o, cor_re_o, cor_im_o);
      end
      rst_ni = 1'b1;
      cyc_step();
      req_re_i[3] = 12'(-2048);
      req_im_i[3] = 12'd2047;
      req_valid_i = 4'b1000;
      #1;
      checks++;
      if (req_ready_o !== 4'b1000) begin
         errors++;
         $display("FAIL midreset_regrant: got %b, want 1000", req_ready_o);
      end
      cyc_step();
      req_valid_i = '0;
      drain();
   endtask

   initial begin
      rst_ni      = 1'b0;
      req_valid_i = '0;
      req_re_i    = '0;
      req_im_i    = '0;
      rsp_ready_i = '1;
      @(negedge clk_i);
      test_reset();
      test_single();
      test_round_robin();
      test_issue_stall();
      test_full();
      test_rsp_backpressure();
      test_error();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
